fib_sched: RTL

- Scheduler that shares one fibonacci engine between NUM_REQ independent requesters.
- Picks a requester by round-robin and sequences the engine's start/done handshake.
- Returns the result tagged with the requester id over a valid/ready response channel.
- Detects a hung engine with a timeout.
- Sits between the client-side request ports and the single fibonacci datapath instance.

---
 rtl/fib_pkg.sv | 29 ++
 rtl/fib_rr_pick.sv | 32 +++
 rtl/fib_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the fibonacci request scheduler.
// fib_ref is a plain iterative reference for use by models around the engine.
package fib_pkg;

  localparam int FIB_N_W = 4;
  localparam int FIB_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrl_state_t;

  function automatic logic [FIB_W-1:0] fib_ref(input logic [FIB_N_W-1:0] n);
    logic [FIB_W-1:0] a;
    logic [FIB_W-1:0] b;
    logic [FIB_W-1:0] t;
    a = '0;
    b = FIB_W'(1);
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

endpackage

// File: rtl/fib_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping modulo NUM_REQ.
// Purely combinational; ptr_i is always below NUM_REQ.
module fib_rr_pick
  import fib_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               any_o,
  output logic [IDW-1:0]     grant_o
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop, so no path leaves a latch.
    any_o   = 1'b0;
    grant_o = '0;
    idx     = 0;
    // Scan from farthest to nearest so the nearest hit is the last write and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fib_sched.sv
// Shares one fibonacci engine among NUM_REQ requesters: round-robin grant,
// start/done sequencing with a hang timeout, and an id-tagged valid/ready response.
module fib_sched
  import fib_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FIB_N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [IDW-1:0]             resp_id,
  output logic [FIB_W-1:0]           resp_data,
  output logic                       resp_err,
  output logic                       eng_start,
  output logic [FIB_N_W-1:0]         eng_n,
  input  logic                       eng_ready,
  input  logic                       eng_done,
  input  logic [FIB_W-1:0]           eng_result,
  output logic                       busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  ctrl_state_t        state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIB_N_W-1:0] n_q, n_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [FIB_W-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic               rvalid_q, rvalid_d;

  logic               pick_any;
  logic [IDW-1:0]     pick_id;
  logic               grant;

  fib_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .any_o   (pick_any),
    .grant_o (pick_id)
  );

  assign grant = (state_q == IDLE) && eng_ready && pick_any;

  // Gated by rst_n so the grant stays low while reset is held, not just after the next edge.
  assign req_ready = (grant && rst_n) ? (NUM_REQ'(1) << pick_id) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    id_d     = id_q;
    res_d    = res_q;
    err_d    = err_q;
    start_d  = 1'b0;
    rvalid_d = rvalid_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          n_d     = req_n[int'(pick_id)*FIB_N_W +: FIB_N_W];
          id_d    = pick_id;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done arriving on the timeout cycle still counts as success.
        if (eng_done) begin
          res_d    = eng_result;
          err_d    = 1'b0;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d    = '0;
          err_d    = 1'b1;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          rr_ptr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      id_q     <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      id_q     <= id_d;
      res_q    <= res_d;
      err_q    <= err_d;
      start_q  <= start_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign eng_start  = start_q;
  assign eng_n      = n_q;
  assign resp_valid = rvalid_q;
  assign resp_id    = id_q;
  assign resp_data  = res_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule
